register_file_dual: RTL
=======================

# register_file_dual

Parametrised two-read/one-write register file: the next generation of the 8×8 single-read-port register file. It keeps asynchronous reads, edge-triggered writes and the asynchronous active-low clear, and adds configurable width and depth, a second read port, an optional hard-wired zero register and a sequenced bulk-clear engine with a write-ready handshake. It sits between decode (read ports) and writeback (write port) in the datapath.

## Interface
- DATA_W, 8, register width in bits
- ADDR_W, 3, register index width; depth DEPTH = 2**ADDR_W (derived, not overridable)
- ZERO_REG, 0, when 1 register 0 reads as 0 and ignores writes
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low; one clock, reset is asynchronous and active-low
- readIdA  input  ADDR_W  read port A index
- readValA  output  DATA_W  read port A data, combinational from readIdA
- readIdB  input  ADDR_W  read port B index
- readValB  output  DATA_W  read port B data, combinational from readIdB
- writeRegId  input  ADDR_W  write index
- writeRegVal  input  DATA_W  write data
- writeEnable  input  1  write request
- writeReady  output  1  high when a write is accepted this cycle (FSM in IDLE)
- clearReq  input  1  request sequenced zeroing of all registers
- clearBusy  output  1  high while clear engine is active (CLEAR or DONE)
- clearDone  output  1  one-cycle pulse on clear completion

## Operation
- Storage: DEPTH × DATA_W flops. Reads are pure combinational muxes; both ports may address the same or any registers simultaneously.
- Write: on rising clk, if writeEnable && writeReady, reg[writeRegId] <= writeRegVal. writeEnable while writeReady=0 is dropped, not queued; writeback must hold the request.
- ZERO_REG=1: writes to index 0 discarded; readVal for index 0 is constant 0.
- Clear FSM, 2-bit state:
  - IDLE: writeReady=1. clearReq=1 at an edge -> CLEAR, ptr <= 0.
  - CLEAR: each edge reg[ptr] <= 0, ptr <= ptr+1; at ptr==DEPTH-1 -> DONE. writeReady=0.
  - DONE: clearDone=1 for one cycle, writeReady=0; next edge -> IDLE.
- clearReq ignored outside IDLE (no queuing).
- clearReq and accepted write at the same IDLE edge: write commits, clear starts; written register is subsequently zeroed.
- ptr is ADDR_W bits; the terminal test prevents wrap.

## Timing
- Reset (reset=0, asynchronous): all registers 0, state IDLE, ptr 0. Outputs during/after reset: readValA/B=0, writeReady=1, clearBusy=0, clearDone=0.
- Reset asserted mid-clear: immediate abort to IDLE with all registers 0; no clearDone pulse.
- Read latency 0 cycles (combinational); written value visible on read ports after the write edge.
- Clear latency: accepting edge + DEPTH cycles in CLEAR + 1 cycle in DONE; writeReady low for DEPTH+1 cycles, clearBusy high for the same window; clearDone high in the last.
- Back-to-back clear: clearReq held high re-triggers on the DONE->IDLE edge only if still high in IDLE (one IDLE cycle minimum between clears).

## Configuration
- REGFILE_BYPASS_EN defined: when writeEnable && writeReady and writeRegId equals readIdA (resp. readIdB), and the write is not discarded by ZERO_REG, readValA (resp. readValB) returns writeRegVal combinationally in the same cycle (write-to-read forwarding).
- Undefined: read ports return stored contents only; new value appears after the edge.

## Test plan
- Reset then sweep readIdA and readIdB 0..7 (defaults) -> all reads 0, writeReady=1, clearBusy=0.
- Write 8'hFF to id 3, 8'hA5 to id 5 on consecutive edges; readIdA=3, readIdB=5 -> 8'hFF and 8'hA5; other ids 0. Write with writeEnable=0 -> no change.
- Fill all registers with id+8'h10, pulse clearReq -> writeReady=0 for 9 cycles, clearDone high on 9th, all reads 0 afterwards; write attempted during CLEAR is dropped.
- Pulse reset low at CLEAR ptr=4 -> immediate IDLE, all registers 0, no clearDone pulse.
- ZERO_REG=1, write 8'h55 to id 0 -> readValA for id 0 stays 0; write to id 1 unaffected.
- With REGFILE_BYPASS_EN, readIdA=2, writeRegId=2, writeRegVal=8'h3C, writeEnable=1 -> readValA=8'h3C before the edge; without the macro, old value until the edge.

Source files
------------

// File: rtl/register_file_dual.sv
// register_file_dual
//
// Two-read / one-write register file with a sequenced bulk-clear engine.
// Decode reads through ports A and B, and writeback writes through the
// single write port. The file holds DEPTH = 2**ADDR_W registers of DATA_W bits.
//
// Reads are purely combinational. A write lands on the rising edge of clk
// when writeEnable is high and writeReady is high. A write request that
// arrives while writeReady is low is dropped; writeback has to hold the
// request until it is accepted.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : an accepted write whose index matches a read index is
//               forwarded combinationally to that read port in the same cycle
//   undefined : read ports only ever return stored contents
//
// Parameters
//   DATA_W   register width in bits
//   ADDR_W   register index width; DEPTH = 2**ADDR_W (derived)
//   ZERO_REG 1 -> register 0 reads as 0 and ignores writes
//
// Ports
//   clk          in   single clock, rising edge
//   reset        in   asynchronous clear, active low
//   readIdA      in   read port A index
//   readValA     out  read port A data (combinational)
//   readIdB      in   read port B index
//   readValB     out  read port B data (combinational)
//   writeRegId   in   write index
//   writeRegVal  in   write data
//   writeEnable  in   write request
//   writeReady   out  a write is accepted this cycle (engine idle)
//   clearReq     in   start a sequenced zeroing of every register
//   clearBusy    out  clear engine active (CLEAR or DONE)
//   clearDone    out  one-cycle pulse in the final cycle of a clear
//
// Clear engine states
//   state | meaning
//   IDLE  | writes accepted; clearReq starts a clear with ptr = 0
//   CLEAR | zero reg[ptr] each edge, ptr advances; leaves after DEPTH-1
//   DONE  | clearDone pulse, writes still blocked; returns to IDLE

module register_file_dual #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] readIdA,
    output logic [DATA_W-1:0] readValA,
    input  logic [ADDR_W-1:0] readIdB,
    output logic [DATA_W-1:0] readValB,
    input  logic [ADDR_W-1:0] writeRegId,
    input  logic [DATA_W-1:0] writeRegVal,
    input  logic              writeEnable,
    output logic              writeReady,
    input  logic              clearReq,
    output logic              clearBusy,
    output logic              clearDone
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CLEAR = 2'b01,
        DONE  = 2'b10
    } clearState_t;

    clearState_t       state;
    clearState_t       nextState;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] regs [DEPTH];
    logic              writeAccept;

    // A write to index 0 is treated as never having happened when register 0
    // is hard-wired. It therefore does not reach storage, and it is not
    // forwarded.
    assign writeAccept = writeEnable && writeReady
                         && !(ZERO_REG && (writeRegId == '0));

    // ---------------------------------------------------------------
    // Clear engine: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // ---------------------------------------------------------------
    // Clear engine: next state and handshake outputs
    // ---------------------------------------------------------------
    always_comb begin
        nextState  = state;
        writeReady = 1'b0;
        clearBusy  = 1'b0;
        clearDone  = 1'b0;
        case (state)
            IDLE: begin
                writeReady = 1'b1;
                if (clearReq) begin
                    nextState = CLEAR;
                end
            end
            CLEAR: begin
                clearBusy = 1'b1;
                if (ptr == LAST_PTR) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                clearBusy = 1'b1;
                clearDone = 1'b1;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Clear pointer. It holds at the last index rather than wrapping, so
    // that it never points back at register 0 while the engine winds down.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (state == IDLE) begin
            if (clearReq) begin
                ptr <= '0;
            end
        end else if (state == CLEAR) begin
            if (ptr != LAST_PTR) begin
                ptr <= ptr + ADDR_W'(1);
            end
        end
    end

    // ---------------------------------------------------------------
    // Storage. writeAccept is only ever high in IDLE, so the write and
    // clear paths never compete for the same edge. A write that shares its
    // IDLE edge with clearReq commits first and is then zeroed in turn.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (state == CLEAR) begin
            regs[ptr] <= '0;
        end else if (writeAccept) begin
            regs[writeRegId] <= writeRegVal;
        end
    end

    // ---------------------------------------------------------------
    // Read ports
    // ---------------------------------------------------------------
    always_comb begin
        readValA = regs[readIdA];
        if (ZERO_REG && (readIdA == '0)) begin
            readValA = '0;
        end
`ifdef REGFILE_BYPASS_EN
        if (writeAccept && (writeRegId == readIdA)) begin
            readValA = writeRegVal;
        end
`endif
    end

    always_comb begin
        readValB = regs[readIdB];
        if (ZERO_REG && (readIdB == '0)) begin
            readValB = '0;
        end
`ifdef REGFILE_BYPASS_EN
        if (writeAccept && (writeRegId == readIdB)) begin
            readValB = writeRegVal;
        end
`endif
    end

endmodule
